// File: rtl/stopwatch_time_gen.sv
// Stopwatch time-word generator: 100 Hz prescaler, cascaded hh:mm:ss.cc counters, run/stop/clear FSM.
// Optional macro WATCH_SET_EN adds hour/min set buttons honoured while stopped.
module stopwatch_time_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_btn_run_stop,
  input  logic        i_btn_clear,
`ifdef WATCH_SET_EN
  input  logic        i_btn_hour_up,
  input  logic        i_btn_min_up,
`endif
  output logic [23:0] o_time_data,
  output logic        o_tick,
  output logic        o_running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_STOP  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pres_q, pres_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    msec_q, msec_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          step_s;
  logic          set_hour_s;
  logic          set_min_s;

`ifdef WATCH_SET_EN
  assign set_hour_s = i_btn_hour_up;
  assign set_min_s  = i_btn_min_up;
`else
  assign set_hour_s = 1'b0;
  assign set_min_s  = 1'b0;
`endif

  assign step_s = (state_q == S_RUN) && (pres_q == PRE_LAST);

  // Next-state logic for FSM, prescaler and the time cascade
  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    msec_d  = msec_q;
    tick_d  = 1'b0;
    case (state_q)
      S_STOP: begin
        if (i_btn_run_stop) begin
          state_d = S_RUN;
        end else if (i_btn_clear) begin
          state_d = S_CLEAR;
        end else begin
          // Set increments wrap within their own field and never carry
          if (set_hour_s) hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
          else            hour_d = hour_q;
          if (set_min_s)  min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
          else            min_d = min_q;
        end
      end
      S_RUN: begin
        if (step_s) begin
          pres_d = {PW{1'b0}};
          tick_d = 1'b1;
          if (msec_q >= 7'd99) begin
            msec_d = 7'd0;
            if (sec_q >= 6'd59) begin
              sec_d = 6'd0;
              if (min_q >= 6'd59) begin
                min_d  = 6'd0;
                hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            msec_d = msec_q + 7'd1;
          end
        end else begin
          pres_d = pres_q + PW'(1);
        end
        if (i_btn_run_stop) state_d = S_STOP;
        else                state_d = S_RUN;
      end
      S_CLEAR: begin
        state_d = S_STOP;
        pres_d  = {PW{1'b0}};
        hour_d  = 5'd0;
        min_d   = 6'd0;
        sec_d   = 6'd0;
        msec_d  = 7'd0;
      end
      default: begin
        state_d = S_STOP;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_STOP;
      pres_q    <= {PW{1'b0}};
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      msec_q    <= 7'd0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pres_q    <= pres_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      msec_q    <= msec_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign o_time_data = {hour_q, min_q, sec_q, msec_q};
  assign o_tick      = tick_q;
  assign o_running   = running_q;

endmodule
